// File: rtl/instruction_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory and fills the IF/ID register.
// Absorbs hazard stalls and branch redirects, including redirects that land on an in-flight access.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter logic [31:0] NOP      = 32'h00000013
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        BRANCH_TAKEN,
   input  logic [31:0] BRANCH_TARGET,
   output logic [31:0] IMEM_ADDRESS,
   output logic        IMEM_READ,
   input  logic        IMEM_BUSYWAIT,
   input  logic [31:0] IMEM_READDATA,
   output logic [31:0] INSTRUCTION,
   output logic [31:0] INST_PC,
   output logic [31:0] PC_PLUS4,
   output logic        VALID
);

   typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] target_pc;
   logic [31:0] buf_word;
   logic        done;

   // Memory handshake depends only on state and PC so the address cannot wobble mid-access.
   assign IMEM_READ    = RESET && (state != HOLD);
   assign IMEM_ADDRESS = pc;
   assign done         = IMEM_READ && !IMEM_BUSYWAIT;
   assign PC_PLUS4     = INST_PC + 32'd4;

   // Redirect beats stall beats normal fetch; a redirect during a pending access parks the
   // target until the memory finishes so the address stays stable.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         target_pc   <= '0;
         buf_word    <= '0;
         INSTRUCTION <= NOP;
         INST_PC     <= '0;
         VALID       <= 1'b0;
      end else if (BRANCH_TAKEN) begin
         INSTRUCTION <= NOP;
         VALID       <= 1'b0;
         buf_word    <= '0;
         if (IMEM_READ && IMEM_BUSYWAIT) begin
            target_pc <= BRANCH_TARGET;
            state     <= DISCARD;
         end else begin
            pc    <= BRANCH_TARGET;
            state <= FETCH;
         end
      end else begin
         case (state)
            FETCH: begin
               if (done) begin
                  pc <= pc + 32'd4;
                  if (!STALL) begin
                     INSTRUCTION <= IMEM_READDATA;
                     INST_PC     <= pc;
                     VALID       <= 1'b1;
                  end else begin
                     buf_word <= IMEM_READDATA;
                     state    <= HOLD;
                  end
               end else if (!STALL) begin
                  INSTRUCTION <= NOP;
                  VALID       <= 1'b0;
               end
            end
            HOLD: begin
               if (!STALL) begin
                  INSTRUCTION <= buf_word;
                  INST_PC     <= pc - 32'd4;
                  VALID       <= 1'b1;
                  state       <= FETCH;
               end
            end
            DISCARD: begin
               if (done) begin
                  pc    <= target_pc;
                  state <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed by a randomized
// run compared against a transaction-level model of the fetch stream.
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        STALL = 1'b0;
   logic        BRANCH_TAKEN = 1'b0;
   logic [31:0] BRANCH_TARGET = '0;
   logic [31:0] IMEM_ADDRESS;
   logic        IMEM_READ;
   logic        IMEM_BUSYWAIT = 1'b0;
   logic [31:0] IMEM_READDATA;
   logic [31:0] INSTRUCTION;
   logic [31:0] INST_PC;
   logic [31:0] PC_PLUS4;
   logic        VALID;

   int errors = 0;
   int checks = 0;

   instruction_fetch_unit #(.RESET_PC(32'h0), .NOP(NOP)) dut (
      .CLK(CLK), .RESET(RESET), .STALL(STALL), .BRANCH_TAKEN(BRANCH_TAKEN),
      .BRANCH_TARGET(BRANCH_TARGET), .IMEM_ADDRESS(IMEM_ADDRESS), .IMEM_READ(IMEM_READ),
      .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .IMEM_READDATA(IMEM_READDATA), .INSTRUCTION(INSTRUCTION),
      .INST_PC(INST_PC), .PC_PLUS4(PC_PLUS4), .VALID(VALID)
   );

   always #5 CLK = ~CLK;

   // Instruction memory contents: two fixed words, the rest a hash of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h00208133;
      if (a == 32'h4) return 32'h40208133;
      return (a * 32'h9E3779B1) ^ 32'h13572468;
   endfunction

   assign IMEM_READDATA = mem_word(IMEM_ADDRESS);

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      #12;
      checks++; if (VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", VALID); end
      checks++; if (INSTRUCTION !== NOP) begin errors++; $display("[TB] FAIL reset_inst got=%h want=%h", INSTRUCTION, NOP); end
      checks++; if (INST_PC !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst_pc got=%h want=0", INST_PC); end
      checks++; if (IMEM_READ !== 1'b0) begin errors++; $display("[TB] FAIL reset_read got=%b want=0", IMEM_READ); end
      checks++; if (IMEM_ADDRESS !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got=%h want=0", IMEM_ADDRESS); end
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   task automatic test_zero_wait();
      tick();
      checks++; if (INSTRUCTION !== 32'h00208133 || INST_PC !== 32'h0 || VALID !== 1'b1) begin
         errors++; $display("[TB] FAIL zw_first got=%h@%h v=%b want=00208133@0 v=1", INSTRUCTION, INST_PC, VALID); end
      tick();
      checks++; if (INSTRUCTION !== 32'h40208133 || INST_PC !== 32'h4 || PC_PLUS4 !== 32'h8) begin
         errors++; $display("[TB] FAIL zw_second got=%h@%h p4=%h want=40208133@4 p4=8", INSTRUCTION, INST_PC, PC_PLUS4); end
   endtask

   task automatic test_busywait();
      IMEM_BUSYWAIT = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (VALID !== 1'b0 || INSTRUCTION !== NOP || IMEM_ADDRESS !== 32'h8) begin
            errors++; $display("[TB] FAIL bw_wait%0d got v=%b i=%h a=%h want v=0 i=%h a=8", i, VALID, INSTRUCTION, IMEM_ADDRESS, NOP); end
      end
      IMEM_BUSYWAIT = 1'b0;
      tick();
      checks++; if (INSTRUCTION !== mem_word(32'h8) || INST_PC !== 32'h8 || VALID !== 1'b1) begin
         errors++; $display("[TB] FAIL bw_done got=%h@%h v=%b want=%h@8", INSTRUCTION, INST_PC, VALID, mem_word(32'h8)); end
      tick();
      checks++; if (INST_PC !== 32'hC || VALID !== 1'b1) begin
         errors++; $display("[TB] FAIL bw_once got pc=%h v=%b want pc=c v=1", INST_PC, VALID); end
   endtask

   task automatic test_stall();
      STALL = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (INST_PC !== 32'hC || INSTRUCTION !== mem_word(32'hC) || IMEM_READ !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_hold%0d got=%h@%h rd=%b want=%h@c rd=0", i, INSTRUCTION, INST_PC, IMEM_READ, mem_word(32'hC)); end
      end
      STALL = 1'b0;
      tick();
      checks++; if (INSTRUCTION !== mem_word(32'h10) || INST_PC !== 32'h10 || VALID !== 1'b1) begin
         errors++; $display("[TB] FAIL stall_buf got=%h@%h v=%b want=%h@10", INSTRUCTION, INST_PC, VALID, mem_word(32'h10)); end
      tick();
      checks++; if (INSTRUCTION !== mem_word(32'h14) || INST_PC !== 32'h14) begin
         errors++; $display("[TB] FAIL stall_next got=%h@%h want=%h@14", INSTRUCTION, INST_PC, mem_word(32'h14)); end
   endtask

   task automatic test_branch_idle();
      BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h100;
      tick();
      BRANCH_TAKEN = 1'b0;
      checks++; if (VALID !== 1'b0 || INSTRUCTION !== NOP) begin
         errors++; $display("[TB] FAIL br_flush got v=%b i=%h want v=0 i=%h", VALID, INSTRUCTION, NOP); end
      tick();
      checks++; if (INSTRUCTION !== mem_word(32'h100) || INST_PC !== 32'h100 || VALID !== 1'b1) begin
         errors++; $display("[TB] FAIL br_target got=%h@%h v=%b want=%h@100", INSTRUCTION, INST_PC, VALID, mem_word(32'h100)); end
   endtask

   task automatic test_branch_pending();
      BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h10;
      tick();
      BRANCH_TAKEN = 1'b0; IMEM_BUSYWAIT = 1'b1;
      tick();
      BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h40;
      tick();
      BRANCH_TAKEN = 1'b0;
      checks++; if (IMEM_ADDRESS !== 32'h10 || VALID !== 1'b0) begin
         errors++; $display("[TB] FAIL brp_discard got a=%h v=%b want a=10 v=0", IMEM_ADDRESS, VALID); end
      tick();
      checks++; if (IMEM_ADDRESS !== 32'h10 || VALID !== 1'b0) begin
         errors++; $display("[TB] FAIL brp_wait got a=%h v=%b want a=10 v=0", IMEM_ADDRESS, VALID); end
      IMEM_BUSYWAIT = 1'b0;
      tick();
      checks++; if (IMEM_ADDRESS !== 32'h40 || VALID !== 1'b0) begin
         errors++; $display("[TB] FAIL brp_drop got a=%h v=%b want a=40 v=0", IMEM_ADDRESS, VALID); end
      tick();
      checks++; if (INSTRUCTION !== mem_word(32'h40) || INST_PC !== 32'h40 || VALID !== 1'b1) begin
         errors++; $display("[TB] FAIL brp_target got=%h@%h v=%b want=%h@40", INSTRUCTION, INST_PC, VALID, mem_word(32'h40)); end
   endtask

   task automatic test_wrap();
      BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'hFFFFFFFC;
      tick();
      BRANCH_TAKEN = 1'b0;
      tick();
      checks++; if (INST_PC !== 32'hFFFFFFFC || PC_PLUS4 !== 32'h0 || IMEM_ADDRESS !== 32'h0 || VALID !== 1'b1) begin
         errors++; $display("[TB] FAIL wrap got pc=%h p4=%h a=%h v=%b want pc=fffffffc p4=0 a=0 v=1", INST_PC, PC_PLUS4, IMEM_ADDRESS, VALID); end
   endtask

   task automatic test_reset_mid_wait();
      IMEM_BUSYWAIT = 1'b1;
      tick();
      #2 RESET = 1'b0;
      #1;
      checks++; if (VALID !== 1'b0 || IMEM_ADDRESS !== 32'h0 || IMEM_READ !== 1'b0 || INSTRUCTION !== NOP) begin
         errors++; $display("[TB] FAIL mid_reset got v=%b a=%h rd=%b i=%h want v=0 a=0 rd=0 i=%h", VALID, IMEM_ADDRESS, IMEM_READ, INSTRUCTION, NOP); end
      IMEM_BUSYWAIT = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   // Fetch-stream model: tracks which address is being fetched, whether a word is parked
   // behind a stall, and whether a late redirect is waiting for the old access to retire.
   task automatic test_random_stream();
      logic [31:0] m_fetch = 32'h0, m_inst = NOP, m_ipc = 32'h0, m_parked_word = '0, m_redirect_to = '0;
      logic        m_valid = 1'b0, m_parked = 1'b0, m_redirect = 1'b0;
      logic        reading, returned;
      for (int cyc = 0; cyc < 600; cyc++) begin
         STALL         = ($urandom_range(0, 3) == 0);
         IMEM_BUSYWAIT = ($urandom_range(0, 2) == 0);
         BRANCH_TAKEN  = ($urandom_range(0, 9) == 0);
         BRANCH_TARGET = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
         @(posedge CLK);
         reading  = !m_parked;
         returned = reading && !IMEM_BUSYWAIT;
         if (BRANCH_TAKEN) begin
            m_valid = 1'b0; m_inst = NOP; m_parked = 1'b0;
            if (reading && IMEM_BUSYWAIT) begin m_redirect = 1'b1; m_redirect_to = BRANCH_TARGET; end
            else begin m_redirect = 1'b0; m_fetch = BRANCH_TARGET; end
         end else if (m_redirect) begin
            if (returned) begin m_redirect = 1'b0; m_fetch = m_redirect_to; end
         end else if (m_parked) begin
            if (!STALL) begin m_inst = m_parked_word; m_ipc = m_fetch - 32'd4; m_valid = 1'b1; m_parked = 1'b0; end
         end else if (returned) begin
            if (STALL) begin m_parked_word = mem_word(m_fetch); m_parked = 1'b1; end
            else begin m_inst = mem_word(m_fetch); m_ipc = m_fetch; m_valid = 1'b1; end
            m_fetch = m_fetch + 32'd4;
         end else if (!STALL) begin
            m_valid = 1'b0; m_inst = NOP;
         end
         #1;
         checks++; if (IMEM_ADDRESS !== m_fetch || IMEM_READ !== !m_parked) begin
            errors++; $display("[TB] FAIL rnd_mem c%0d got a=%h rd=%b want a=%h rd=%b", cyc, IMEM_ADDRESS, IMEM_READ, m_fetch, !m_parked); end
         checks++; if (VALID !== m_valid || INSTRUCTION !== m_inst) begin
            errors++; $display("[TB] FAIL rnd_out c%0d got v=%b i=%h want v=%b i=%h", cyc, VALID, INSTRUCTION, m_valid, m_inst); end
         if (m_valid) begin
            checks++; if (INST_PC !== m_ipc || PC_PLUS4 !== m_ipc + 32'd4) begin
               errors++; $display("[TB] FAIL rnd_pc c%0d got pc=%h p4=%h want pc=%h", cyc, INST_PC, PC_PLUS4, m_ipc); end
         end
      end
      BRANCH_TAKEN = 1'b0; STALL = 1'b0; IMEM_BUSYWAIT = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_busywait();
      test_stall();
      test_branch_idle();
      test_branch_pending();
      test_wrap();
      test_reset_mid_wait();
      test_random_stream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction-fetch stage of the RV32IM pipelined CPU. It produces the INSTRUCTION word that the control unit decodes. It owns the program counter and drives a read-only handshake to instruction memory. It loads the IF/ID output register with the instruction, its PC and a valid flag, and absorbs pipeline stalls and branch/jump redirects, including redirects that arrive while a memory access is in flight.

## Interface
Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset
- NOP, 32'h00000013, bubble word (addi x0,x0,0) driven when INSTRUCTION is not valid

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-low reset
- STALL  in  1  hazard unit hold request for the IF/ID register
- BRANCH_TAKEN  in  1  redirect request, one-cycle pulse from EX
- BRANCH_TARGET  in  32  redirect PC, valid while BRANCH_TAKEN=1
- IMEM_ADDRESS  out  32  fetch address, equals PC
- IMEM_READ  out  1  read request
- IMEM_BUSYWAIT  in  1  memory not ready; access completes on an edge where IMEM_READ=1 and IMEM_BUSYWAIT=0
- IMEM_READDATA  in  32  instruction word, sampled on the completing edge
- INSTRUCTION  out  32  IF/ID instruction to the control unit
- INST_PC  out  32  PC of INSTRUCTION
- PC_PLUS4  out  32  INST_PC+4, used as the JAL/JALR link value
- VALID  out  1  INSTRUCTION is real; when 0, INSTRUCTION=NOP

## Operation
- States: FETCH, HOLD, DISCARD. Registers: PC, buffer word BUF, IF/ID outputs.
- Reset (RESET=0, asynchronous): state=FETCH, PC=RESET_PC, INSTRUCTION=NOP, INST_PC=0, VALID=0, BUF=0. IMEM_READ is forced to 0 while RESET=0.
- IMEM_READ=1 in FETCH and DISCARD, 0 in HOLD. IMEM_ADDRESS=PC at all times.
- PC is stable while an access is pending. IMEM_ADDRESS never changes mid-access.
- "Done" means the current edge has IMEM_READ=1 and IMEM_BUSYWAIT=0.
- Edge priority, highest first: BRANCH_TAKEN, then STALL, then normal fetch.
- BRANCH_TAKEN=1 (any state):
  - outputs flush: VALID=0, INSTRUCTION=NOP. BUF is dropped.
  - If an access is pending and not done (IMEM_READ=1 and IMEM_BUSYWAIT=1), latch the target into PC-next and go to DISCARD. PC stays unchanged until the access completes.
  - Otherwise PC=BRANCH_TARGET and state=FETCH. Returning data on that edge is dropped.
- FETCH with done and STALL=0: INSTRUCTION=IMEM_READDATA, INST_PC=PC, VALID=1, PC=PC+4, stay in FETCH.
- FETCH with done and STALL=1: BUF=IMEM_READDATA, PC=PC+4, go to HOLD. IF/ID outputs hold.
- FETCH, not done:
  - STALL=0: VALID=0, INSTRUCTION=NOP (bubble).
  - STALL=1: outputs hold.
- HOLD:
  - STALL=1: everything holds.
  - STALL=0: INSTRUCTION=BUF, INST_PC=PC-4, VALID=1, go to FETCH.
- DISCARD: on done, drop the data, PC=latched target, go to FETCH. The IF/ID outputs stay flushed.
- A second BRANCH_TAKEN in DISCARD overwrites the latched target.
- PC arithmetic is modulo 2^32; 32'hFFFFFFFC+4 wraps to 0. PC_PLUS4 wraps the same way.

## Timing
- Zero-wait memory (IMEM_BUSYWAIT=0): one instruction per cycle. The first valid INSTRUCTION (address RESET_PC) appears after the first rising edge following RESET release.
- N wait cycles: the instruction appears on the edge after IMEM_BUSYWAIT falls. Every intervening non-stalled cycle shows VALID=0.
- Redirect penalty with zero-wait memory: one bubble cycle, then the target instruction. With a pending access: the remaining wait cycles plus one cycle.
- The IF/ID outputs, PC and BUF are registered. IMEM_READ and IMEM_ADDRESS are combinational from state and PC only, never from IMEM_BUSYWAIT.
- RESET asserted mid-access: immediate return to reset values. The in-flight memory response is ignored.

## Test plan
- Reset, RESET_PC=0, zero-wait memory holding 32'h00208133 at 0 and 32'h40208133 at 4 -> edge 1: INSTRUCTION=00208133, INST_PC=0, VALID=1; edge 2: INSTRUCTION=40208133, INST_PC=4, PC_PLUS4=8.
- IMEM_BUSYWAIT=1 for 3 cycles on the fetch at 0x8 -> VALID=0 and INSTRUCTION=NOP for 3 cycles; the word at 0x8 then appears once and IMEM_ADDRESS stays 0x8 throughout.
- STALL=1 for 2 cycles with zero-wait memory -> INSTRUCTION holds, FSM enters HOLD with IMEM_READ=0; after release the buffered word at the next PC appears, with no loss or duplication.
- BRANCH_TAKEN with BRANCH_TARGET=0x100 while idle-ready -> next edge VALID=0; the following edge INSTRUCTION=mem[0x100], INST_PC=0x100.
- BRANCH_TAKEN (target 0x40) during a 2-cycle-busy fetch at 0x10 -> DISCARD; mem[0x10] never reaches VALID=1; the next valid INSTRUCTION has INST_PC=0x40.
- PC=32'hFFFFFFFC, zero-wait memory -> after the fetch, IMEM_ADDRESS=0 and PC_PLUS4=0; RESET pulsed low mid-wait -> VALID=0 and PC=RESET_PC immediately.
